compensation_ctrl: RTL
======================

COMPENSATION_CTRL -- requirements
Module: compensation_ctrl

Interface
REQ-001 SHALL have parameter BEAT_W, default 8, meaning the width of the beat-count field.
REQ-002 SHALL have parameter SUM_W, default 22, meaning the accumulator result width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  meaning a request to begin one accumulation job.
REQ-006 SHALL have port num_beats  input  BEAT_W  meaning the number of compensation beats in the job, sampled with start.
REQ-007 SHALL have port in_valid  input  1  meaning the systolic array presents a compensation beat this cycle.
REQ-008 SHALL have port abort  input  1  meaning discard the current job.
REQ-009 SHALL have port acc_sum  input  SUM_W  meaning the accumulator's registered sum output.
REQ-010 SHALL have port out_ready  input  1  meaning the downstream consumer accepts out_sum.
REQ-011 SHALL have port cal  output  1  meaning the accumulate enable driven to the accumulator.
REQ-012 SHALL have port acc_clr  output  1  meaning a one-cycle active-high clear driven to the accumulator.
REQ-013 SHALL have port busy  output  1  meaning state is not IDLE.
REQ-014 SHALL have port out_valid  output  1  meaning out_sum holds a completed job result.
REQ-015 SHALL have port out_sum  output  SUM_W  meaning the captured job result.
REQ-016 SHALL have port start_err  output  1  meaning a one-cycle pulse when a start is rejected.
REQ-017 SHALL have port jobs_done  output  16  meaning the count of results handed off; wraps from 0xFFFF to 0.

Function
REQ-018 SHALL implement states IDLE, ACCUM, SETTLE, OUT and CLEAR, all registered.
REQ-019 In IDLE, start=1 with num_beats!=0 SHALL latch num_beats, zero the beat counter and enter ACCUM on the next edge.
REQ-020 In IDLE, start=1 with num_beats==0 SHALL pulse start_err for one cycle and remain in IDLE.
REQ-021 A start outside IDLE SHALL be ignored without a start_err pulse.
REQ-022 cal SHALL be combinational: in_valid AND state==ACCUM AND abort==0; it is 0 in every other state.
REQ-023 Each cycle with cal=1 SHALL increment the beat counter.
REQ-024 When cal=1 and the counter equals latched num_beats-1, the next state SHALL be SETTLE.
REQ-025 A cycle in ACCUM with in_valid=0 SHALL be a stall: the counter holds and there is no timeout.
REQ-026 SETTLE SHALL last exactly one cycle, because acc_sum is registered one cycle after the final cal.
REQ-027 At the end of SETTLE, out_sum SHALL capture acc_sum, out_valid SHALL set and the state SHALL become OUT.
REQ-028 In OUT, out_valid and out_sum SHALL hold stable until out_ready=1.
REQ-029 In OUT, out_valid AND out_ready SHALL increment jobs_done, clear out_valid on the next edge and enter CLEAR.
REQ-030 In CLEAR, acc_clr SHALL be 1 for exactly that one cycle, after which the state SHALL be IDLE; a start in CLEAR is ignored.
REQ-031 In ACCUM or SETTLE, abort=1 SHALL enter CLEAR next edge, produce no output and leave jobs_done unchanged; abort has priority over a completing beat.
REQ-032 abort SHALL be ignored in IDLE, OUT and CLEAR.
REQ-033 out_sum SHALL keep its last captured value after the handoff.
REQ-034 Minimum job latency SHALL be: start at cycle 0, first cal at cycle 1, last cal at cycle N, out_valid at cycle N+2.

Reset
REQ-035 On rst=0, asynchronously: state=IDLE, beat counter=0, cal=0, acc_clr=0, busy=0, out_valid=0, out_sum=0, start_err=0, jobs_done=0.
REQ-036 A reset mid-job SHALL drop the job without an acc_clr pulse; the accumulator is reset by its own reset.
REQ-037 After rst returns to 1, the first start SHALL be honoured on the first clock edge.

Verification
REQ-038 Bench: start with num_beats=4 and in_valid held at 1 -> cal high in cycles 1-4; out_valid at cycle 6 with out_sum equal to acc_sum; with out_ready=1, acc_clr in cycle 7, IDLE in cycle 8, jobs_done=1.
REQ-039 Bench: num_beats=3 with in_valid pattern 1,0,0,1,1 -> exactly 3 cal pulses; SETTLE follows the 5th ACCUM cycle.
REQ-040 Bench: start with num_beats=0 -> single start_err pulse, busy stays 0, no cal.
REQ-041 Bench: out_ready held at 0 for 10 cycles in OUT -> out_valid and out_sum stable; a start pulse in that window is ignored.
REQ-042 Bench: abort on the cycle the final beat arrives -> cal=0 that cycle, then CLEAR with acc_clr=1, no out_valid, jobs_done unchanged.
REQ-043 Bench: rst=0 asserted mid-ACCUM between clock edges -> all outputs 0 immediately; preload jobs_done=0xFFFF then complete one job -> jobs_done=0.

Source files
------------

// File: rtl/compensation_ctrl.sv
// Sequences one compensation accumulation job: counts accepted beats, waits for the
// registered accumulator sum, holds the result until it is taken, then clears the accumulator.
module compensation_ctrl #(
    parameter int BEAT_W = 8,
    parameter int SUM_W  = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BEAT_W-1:0] num_beats,
    input  logic              in_valid,
    input  logic              abort,
    input  logic [SUM_W-1:0]  acc_sum,
    input  logic              out_ready,
    output logic              cal,
    output logic              acc_clr,
    output logic              busy,
    output logic              out_valid,
    output logic [SUM_W-1:0]  out_sum,
    output logic              start_err,
    output logic [15:0]       jobs_done
);

    // state  | meaning
    // IDLE   | waiting for start
    // ACCUM  | enabling the accumulator on each valid beat
    // SETTLE | final beat is landing in acc_sum
    // OUT    | result held until out_ready
    // CLEAR  | one-cycle accumulator clear
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCUM  = 3'd1,
        SETTLE = 3'd2,
        OUT    = 3'd3,
        CLEAR  = 3'd4
    } state_t;

    localparam logic [BEAT_W-1:0] BEAT_ONE  = 1;
    localparam logic [BEAT_W-1:0] BEAT_ZERO = '0;

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  nbeats_q, nbeats_d;
    logic [BEAT_W-1:0]  cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [SUM_W-1:0]   out_sum_q, out_sum_d;
    logic               start_err_q, start_err_d;
    logic [15:0]        jobs_done_q, jobs_done_d;
    logic               cal_c;
    logic               acc_clr_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            nbeats_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            start_err_q <= 1'b0;
            jobs_done_q <= '0;
        end else begin
            state_q     <= state_d;
            nbeats_q    <= nbeats_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            start_err_q <= start_err_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        nbeats_d    = nbeats_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        start_err_d = 1'b0;
        jobs_done_d = jobs_done_q;
        cal_c       = 1'b0;
        acc_clr_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_beats != BEAT_ZERO) begin
                        nbeats_d = num_beats;
                        cnt_d    = '0;
                        state_d  = ACCUM;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            ACCUM: begin
                // abort wins over a completing beat; a missing beat is a stall
                if (abort) begin
                    state_d = CLEAR;
                end else if (in_valid) begin
                    cal_c = 1'b1;
                    cnt_d = cnt_q + BEAT_ONE;
                    if (cnt_q == nbeats_q - BEAT_ONE) begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = CLEAR;
                end else begin
                    out_sum_d   = acc_sum;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    jobs_done_d = jobs_done_q + 16'd1;
                    out_valid_d = 1'b0;
                    state_d     = CLEAR;
                end
            end
            CLEAR: begin
                acc_clr_c = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cal       = cal_c;
    assign acc_clr   = acc_clr_c;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign start_err = start_err_q;
    assign jobs_done = jobs_done_q;

endmodule
